// File: rtl/dds_sample_capture.sv
// -----------------------------------------------------------------------------
// dds_sample_capture
// Multi-channel sample recorder for the DDS chain. After an arm pulse it waits
// for a trigger on the accepted sample strobes, records cap_len strobes of all
// N_CH channels into block RAM, then replays them as a valid/ready stream
// ordered idx0 ch0..chN-1, idx1 ch0.., ...
//
// Optional feature macro: CAPTURE_DECIM_EN
//   defined   -> extra input decim[7:0]; only every (decim+1)-th strobe after
//                arm is accepted (the first one is).
//   undefined -> every sample_en is accepted.
//
// Ports
//   sysclk, reset            clock, asynchronous active-high reset
//   sample_en, sample_data   strobe and packed channel samples (ch0 in LSBs)
//   arm                      start one capture (ignored while busy)
//   trig_mode/level/ch       00 immediate, 01 rising, 10 falling, 11 ext_trig
//   ext_trig                 external trigger, looked at on accepted strobes
//   cap_len                  samples per channel (0 or >DEPTH means DEPTH)
//   busy, done               activity flag, one-cycle end-of-readout pulse
//   rd_valid/ready/data/ch/last  readout stream
// -----------------------------------------------------------------------------
module dds_sample_capture #(
  parameter int SAMPLE_W = 12,
  parameter int N_CH     = 2,
  parameter int DEPTH    = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic [N_CH*SAMPLE_W-1:0] sample_data,
  input  logic                     arm,
  input  logic [1:0]               trig_mode,
  input  logic [SAMPLE_W-1:0]      trig_level,
  input  logic [CW-1:0]            trig_ch,
  input  logic                     ext_trig,
  input  logic [AW:0]              cap_len,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]               decim,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [SAMPLE_W-1:0]      rd_data,
  output logic [CW-1:0]            rd_ch,
  output logic                     rd_last
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_e;
  typedef enum logic [1:0] {TRIG_IMM, TRIG_RISE, TRIG_FALL, TRIG_EXT} trig_e;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_e              state_q, state_d;
  trig_e               mode_q, mode_d;
  logic [SAMPLE_W-1:0] level_q, level_d, prev_q, prev_d, cur;
  logic [CW-1:0]       tch_q, tch_d;
  logic [AW:0]         len_q, len_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic                prev_vld_q, prev_vld_d;
  logic [CW-1:0]       rd_chan_q, rd_chan_d, s1_ch_q, s1_ch_d, rd_ch_q, rd_ch_d;
  logic                issued_all_q, issued_all_d;
  logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic                rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [SAMPLE_W-1:0] rd_data_q, rd_data_d;
  logic                accept, trig_hit, wr_en;
  logic                out_free, s1_free, xfer, issue, issue_last;

  logic [N_CH*SAMPLE_W-1:0] mem [DEPTH];
  logic [N_CH*SAMPLE_W-1:0] ram_rd_q;
  logic [SAMPLE_W-1:0]      in_ch   [N_CH];
  logic [SAMPLE_W-1:0]      word_ch [N_CH];

`ifdef CAPTURE_DECIM_EN
  logic [7:0] decim_q, decim_d, dcnt_q, dcnt_d;

  assign accept = sample_en && (dcnt_q == 8'd0);

  // The strobe counter restarts at arm so the first strobe afterwards is taken.
  always_comb begin
    decim_d = decim_q;
    dcnt_d  = dcnt_q;
    if (state_q == IDLE) begin
      if (arm) begin
        decim_d = decim;
        dcnt_d  = 8'd0;
      end
    end else if (sample_en && (state_q == ARMED || state_q == CAPTURE)) begin
      dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      decim_q <= 8'd0;
      dcnt_q  <= 8'd0;
    end else begin
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
    end
  end
`else
  assign accept = sample_en;
`endif

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      in_ch[i]   = sample_data[i*SAMPLE_W +: SAMPLE_W];
      word_ch[i] = ram_rd_q[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  assign cur = in_ch[tch_q];

  always_comb begin
    case (mode_q)
      TRIG_IMM:  trig_hit = 1'b1;
      TRIG_RISE: trig_hit = prev_vld_q && (prev_q <  level_q) && (cur >= level_q);
      TRIG_FALL: trig_hit = prev_vld_q && (prev_q >= level_q) && (cur <  level_q);
      TRIG_EXT:  trig_hit = ext_trig;
      default:   trig_hit = 1'b0;
    endcase
  end

  // Capture control.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    level_d    = level_q;
    tch_d      = tch_q;
    len_d      = len_q;
    wr_idx_d   = wr_idx_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: if (arm) begin
        state_d    = ARMED;
        mode_d     = trig_e'(trig_mode);
        level_d    = trig_level;
        tch_d      = (int'(trig_ch) >= N_CH) ? '0 : trig_ch;
        len_d      = ((cap_len == '0) || (cap_len > DEPTH_L)) ? DEPTH_L : cap_len;
        wr_idx_d   = '0;
        prev_vld_d = 1'b0;
      end
      ARMED: if (accept) begin
        // Every accepted strobe refreshes prev, so the first one only primes it.
        prev_d     = cur;
        prev_vld_d = 1'b1;
        wr_en      = trig_hit;
      end
      CAPTURE: wr_en = accept;
      READOUT: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_en) begin
      wr_idx_d = wr_idx_q + ONE;
      state_d  = (wr_idx_q + ONE == len_q) ? READOUT : CAPTURE;
    end
  end

  // Readout pipeline: issue (address) -> RAM register (s1) -> output register.
  // A stalled stage holds, and the RAM register only reloads on an issue, so
  // the stream keeps one beat per cycle yet freezes cleanly on backpressure.
  assign out_free   = !rd_valid_q || rd_ready;
  assign s1_free    = !s1_vld_q || out_free;
  assign xfer       = rd_valid_q && rd_ready;
  assign issue      = (state_q == READOUT) && !issued_all_q && s1_free;
  assign issue_last = (rd_idx_q == len_q - ONE) && (rd_chan_q == LAST_CH);
  assign done       = xfer && rd_last_q;

  always_comb begin
    rd_idx_d     = rd_idx_q;
    rd_chan_d    = rd_chan_q;
    issued_all_d = issued_all_q;
    s1_vld_d     = s1_vld_q;
    s1_ch_d      = s1_ch_q;
    s1_last_d    = s1_last_q;
    rd_valid_d   = rd_valid_q;
    rd_data_d    = rd_data_q;
    rd_ch_d      = rd_ch_q;
    rd_last_d    = rd_last_q;
    if (state_q != READOUT) begin
      rd_idx_d     = '0;
      rd_chan_d    = '0;
      issued_all_d = 1'b0;
      s1_vld_d     = 1'b0;
      rd_valid_d   = 1'b0;
      rd_last_d    = 1'b0;
    end else begin
      if (s1_free) begin
        s1_vld_d  = issue;
        s1_ch_d   = rd_chan_q;
        s1_last_d = issue_last;
      end
      if (issue) begin
        if (rd_chan_q == LAST_CH) begin
          rd_chan_d = '0;
          rd_idx_d  = rd_idx_q + ONE;
        end else begin
          rd_chan_d = rd_chan_q + CW'(1);
        end
        if (issue_last) issued_all_d = 1'b1;
      end
      if (out_free) begin
        rd_valid_d = s1_vld_q;
        rd_last_d  = s1_vld_q && s1_last_q;
        if (s1_vld_q) begin
          rd_data_d = word_ch[s1_ch_q];
          rd_ch_d   = s1_ch_q;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= TRIG_IMM;
      level_q      <= '0;
      tch_q        <= '0;
      len_q        <= '0;
      wr_idx_q     <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      rd_idx_q     <= '0;
      rd_chan_q    <= '0;
      issued_all_q <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_ch_q      <= '0;
      s1_last_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_ch_q      <= '0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      level_q      <= level_d;
      tch_q        <= tch_d;
      len_q        <= len_d;
      wr_idx_q     <= wr_idx_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      rd_idx_q     <= rd_idx_d;
      rd_chan_q    <= rd_chan_d;
      issued_all_q <= issued_all_d;
      s1_vld_q     <= s1_vld_d;
      s1_ch_q      <= s1_ch_d;
      s1_last_q    <= s1_last_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_ch_q      <= rd_ch_d;
      rd_last_q    <= rd_last_d;
    end
  end

  // NOTE: the sample RAM and its read register have no reset; their contents
  // are never observed before being written, and a reset would stop the
  // array mapping onto block RAM.
  always_ff @(posedge sysclk) begin
    if (wr_en) mem[wr_idx_q[AW-1:0]] <= sample_data;
    if (issue) ram_rd_q <= mem[rd_idx_q[AW-1:0]];
  end

  assign busy     = (state_q != IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_ch    = rd_ch_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_dds_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_dds_sample_capture
// Drives arm/strobe sequences, predicts the replayed record from the capture
// rules (trigger search over the list of accepted strobes), queues the expected
// beats, and lets an independent monitor compare every transferred beat.
// -----------------------------------------------------------------------------
module tb_dds_sample_capture;
  localparam int SAMPLE_W = 12;
  localparam int N_CH     = 2;
  localparam int DEPTH    = 1024;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int MAXS     = 2048;

  logic                     sysclk = 1'b0;
  logic                     reset = 1'b1;
  logic                     sample_en = 1'b0;
  logic [N_CH*SAMPLE_W-1:0] sample_data = '0;
  logic                     arm = 1'b0;
  logic [1:0]               trig_mode = '0;
  logic [SAMPLE_W-1:0]      trig_level = '0;
  logic [CW-1:0]            trig_ch = '0;
  logic                     ext_trig = 1'b0;
  logic [AW:0]              cap_len = '0;
`ifdef CAPTURE_DECIM_EN
  logic [7:0]               decim = '0;
`endif
  logic                     busy, done, rd_valid, rd_last;
  logic                     rd_ready = 1'b1;
  logic [SAMPLE_W-1:0]      rd_data;
  logic [CW-1:0]            rd_ch;

  always #4 sysclk = ~sysclk;

  dds_sample_capture #(.SAMPLE_W(SAMPLE_W), .N_CH(N_CH), .DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .reset(reset), .sample_en(sample_en), .sample_data(sample_data),
    .arm(arm), .trig_mode(trig_mode), .trig_level(trig_level), .trig_ch(trig_ch),
    .ext_trig(ext_trig), .cap_len(cap_len),
`ifdef CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_ch(rd_ch), .rd_last(rd_last)
  );

  typedef struct {
    int data;
    int ch;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  int    smp [0:MAXS-1][0:N_CH-1];
  bit    ext_a [0:MAXS-1];
  int    ready_mode = 0;
  int    rdy_cyc = 0;
  bit    pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: list the accepted strobes, search the trigger over them, and
  // the record is the next len accepted strobes, every channel per index.
  function automatic bit model(input int mode, input int level, input int tch,
                               input int len, input int dec, input int n);
    int acc[$];
    int t, eff_len, eff_ch, cur, prv;
    for (int k = 0; k < n; k++) if (k % (dec + 1) == 0) acc.push_back(k);
    eff_len = (len == 0 || len > DEPTH) ? DEPTH : len;
    eff_ch  = (tch >= N_CH) ? 0 : tch;
    t   = -1;
    prv = 0;
    for (int j = 0; j < acc.size() && t < 0; j++) begin
      cur = smp[acc[j]][eff_ch];
      case (mode)
        0: t = j;
        1: if (j > 0 && prv < level && cur >= level) t = j;
        2: if (j > 0 && prv >= level && cur < level) t = j;
        default: if (ext_a[acc[j]]) t = j;
      endcase
      prv = cur;
    end
    if (t < 0 || t + eff_len > acc.size()) return 1'b0;
    for (int i = 0; i < eff_len; i++)
      for (int c = 0; c < N_CH; c++)
        exp_q.push_back('{data: smp[acc[t+i]][c], ch: c,
                          last: (i == eff_len - 1) && (c == N_CH - 1)});
    return 1'b1;
  endfunction

  // Consumer readiness: 0 always ready, 1 random, 2 repeating 1-0-1-1-0.
  initial begin
    forever begin
      @(posedge sysclk); #1;
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = pat[rdy_cyc % 5];
      endcase
      rdy_cyc++;
    end
  end

  // Monitor: pops one expectation per transfer, checks holds during stalls.
  logic                stall_prev = 1'b0;
  logic [SAMPLE_W-1:0] hold_data = '0;
  logic [CW-1:0]       hold_ch = '0;
  logic                hold_last = 1'b0;

  always @(negedge sysclk) begin
    if (reset) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", rd_valid, 1);
        check("hold_data", rd_data, hold_data);
        check("hold_ch", rd_ch, hold_ch);
        check("hold_last", rd_last, hold_last);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: data=%0d ch=%0d arrived with nothing expected", rd_data, rd_ch);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_ch", rd_ch, e.ch);
          check("rd_last", rd_last, e.last);
          check("done_on_beat", done, e.last);
        end
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL done_without_transfer: done=1 required 0");
      end
      stall_prev <= rd_valid && !rd_ready;
      hold_data  <= rd_data;
      hold_ch    <= rd_ch;
      hold_last  <= rd_last;
    end
  end

  task automatic pulse_reset();
    @(posedge sysclk); #2;
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    exp_q.delete();
    @(posedge sysclk); #1;
    reset = 1'b0;
  endtask

  // Arm pulse; optionally with a coinciding strobe that must not be examined.
  task automatic do_arm(input int mode, input int level, input int tch, input int len,
                        input int dec, input bit with_strobe);
    @(posedge sysclk); #1;
    arm        = 1'b1;
    trig_mode  = 2'(mode);
    trig_level = SAMPLE_W'(level);
    trig_ch    = CW'(tch);
    cap_len    = (AW+1)'(len);
`ifdef CAPTURE_DECIM_EN
    decim      = 8'(dec);
`endif
    if (with_strobe) begin
      sample_en = 1'b1;
      for (int c = 0; c < N_CH; c++) sample_data[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(7);
      ext_trig  = 1'b1;
    end
    @(posedge sysclk); #1;
    arm       = 1'b0;
    sample_en = 1'b0;
    ext_trig  = 1'b0;
  endtask

  task automatic send_strobes(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      sample_en = 1'b1;
      for (int c = 0; c < N_CH; c++) sample_data[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(smp[k][c]);
      ext_trig = ext_a[k];
      @(posedge sysclk); #1;
      sample_en   = 1'b0;
      sample_data = (N_CH*SAMPLE_W)'({$urandom(), $urandom()});
      ext_trig    = 1'($urandom_range(0, 1));
      for (int g = 1; g < gap; g++) begin
        @(posedge sysclk); #1;
      end
    end
    ext_trig = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
      pulse_reset();
    end
  endtask

  task automatic run(input string tag, input int mode, input int level, input int tch,
                     input int len, input int dec, input int n, input int gap,
                     input bit arm_strobe, input bit rearm_mid);
    bit hit;
    int d0;
    d0  = done_cnt;
    hit = model(mode, level, tch, len, dec, n);
    do_arm(mode, level, tch, len, dec, arm_strobe);
    send_strobes(n, gap);
    if (hit) begin
      if (rearm_mid) begin
        repeat (20) @(posedge sysclk);
        check({tag, "_busy_in_readout"}, busy, 1);
        do_arm(0, 0, 0, 2, 0, 1'b0);
      end
      wait_done(d0, 20000);
      repeat (4) @(negedge sysclk);
      check({tag, "_done_count"}, done_cnt - d0, 1);
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_idle_after"}, busy, 0);
      check({tag, "_valid_after"}, rd_valid, 0);
    end else begin
      @(negedge sysclk);
      check({tag, "_still_armed"}, busy, 1);
      check({tag, "_no_valid"}, rd_valid, 0);
      pulse_reset();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv, ln;
    repeat (3) @(posedge sysclk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_ch", rd_ch, 0);
    @(posedge sysclk); #1;
    reset = 1'b0;

    // Immediate trigger, ch0=k, ch1=100+k, 4 samples.
    for (int k = 0; k < 8; k++) begin
      smp[k][0] = k; smp[k][1] = 100 + k; ext_a[k] = 1'b0;
    end
    run("imm", 0, 0, 0, 4, 0, 8, 3, 1'b1, 1'b0);

    // Rising crossing on ch1 at 2048; ramp 2040..2060 step 4.
    for (int k = 0; k < 6; k++) begin
      smp[k][0] = int'($urandom_range(0, 4095)); smp[k][1] = 2040 + 4*k; ext_a[k] = 1'b0;
    end
    run("rise", 1, 2048, 1, 3, 0, 6, 2, 1'b1, 1'b0);

    // Ramp already above level: the first strobe only primes prev, no trigger.
    for (int k = 0; k < 6; k++) smp[k][1] = 2050 + 4*k;
    run("rise_none", 1, 2048, 1, 3, 0, 6, 2, 1'b1, 1'b0);

    // Stalling consumer with the 1-0-1-1-0 pattern, same record as first run.
    for (int k = 0; k < 8; k++) begin
      smp[k][0] = k; smp[k][1] = 100 + k;
    end
    ready_mode = 2;
    run("stall", 0, 0, 0, 4, 0, 8, 2, 1'b0, 1'b0);

    // Random modes, levels, lengths and data under random backpressure.
    ready_mode = 1;
    for (int it = 0; it < 6; it++) begin
      ln = int'($urandom_range(1, 12));
      lv = int'($urandom_range(0, 4095));
      for (int k = 0; k < ln + 24; k++) begin
        for (int c = 0; c < N_CH; c++) smp[k][c] = int'($urandom_range(0, 4095));
        ext_a[k] = ($urandom_range(0, 3) == 0);
      end
      run("rand", int'($urandom_range(0, 3)), lv, int'($urandom_range(0, N_CH - 1)),
          ln, 0, ln + 24, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Full depth via cap_len=0; an arm pulse during readout must be ignored.
    ready_mode = 0;
    for (int k = 0; k < DEPTH; k++)
      for (int c = 0; c < N_CH; c++) smp[k][c] = int'($urandom_range(0, 4095));
    run("full", 0, 0, 0, 0, 0, DEPTH, 2, 1'b0, 1'b1);

    // Reset in the middle of a capture, then a clean short capture.
    begin
      int d0;
      d0 = done_cnt;
      do_arm(0, 0, 0, 8, 0, 1'b0);
      send_strobes(3, 2);
      pulse_reset();
      repeat (3) @(negedge sysclk);
      check("abort_no_done", done_cnt - d0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      smp[k][0] = 10 + k; smp[k][1] = 200 + k;
    end
    run("after_abort", 0, 0, 0, 2, 0, 4, 2, 1'b0, 1'b0);

`ifdef CAPTURE_DECIM_EN
    // Decimation by 3: stored samples come from strobes 0,3,6,9.
    for (int k = 0; k < 12; k++) begin
      smp[k][0] = k; smp[k][1] = 50 + k; ext_a[k] = 1'b0;
    end
    run("decim", 0, 0, 0, 4, 2, 12, 2, 1'b1, 1'b0);
`endif

    repeat (5) @(posedge sysclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
